// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-port RAM arbiter and its read tag pipeline.
package ram_arb_pkg;

  localparam int AW_DEF  = 10;
  localparam int DW_DEF  = 32;
  localparam int NUM_REQ = 2;

  typedef logic req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rd_tag_t;

endpackage

// File: rtl/ram_rd_tag_pipe.sv
// Read tag shift register: remembers which requester issued each in-flight read
// and routes the RAM output back to that requester RD_LAT cycles later.
module ram_rd_tag_pipe
  import ram_arb_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int DW     = DW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_acc_i,
  input  req_id_t            rd_id_i,
  input  logic [DW-1:0]      ram_q_i,
  output logic [NUM_REQ-1:0] rsp_valid_o,
  output logic [DW-1:0]      rsp_rdata_o
);

  rd_tag_t           tag_in;
  rd_tag_t           tag_out;
  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] vld_d;
  req_id_t           id_q [RD_LAT];
  req_id_t           id_d [RD_LAT];

  assign tag_in = '{valid: rd_acc_i, id: rd_id_i};

  always_comb begin
    vld_d[0] = tag_in.valid;
    id_d[0]  = tag_in.id;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      id_d[i]  = id_q[i-1];
    end
  end

  // Stage boundary: only the valid bits need reset; ids are qualified by them.
  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < RD_LAT; i++) id_q[i] <= id_d[i];
  end

  assign tag_out = '{valid: vld_q[RD_LAT-1], id: id_q[RD_LAT-1]};

  // Gating with rst keeps a response from leaking out in the reset cycle itself.
  always_comb begin
    rsp_valid_o = '0;
    rsp_rdata_o = '0;
    if (tag_out.valid && !rst) begin
      rsp_valid_o[tag_out.id] = 1'b1;
      rsp_rdata_o             = ram_q_i;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two requesters.
// Optional saturating grant/conflict counters are enabled with RAM_ARB_STATS_EN.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ-1:0][AW-1:0] req_addr,
  input  logic [NUM_REQ-1:0][DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DW-1:0]              rsp_rdata,
  output logic [AW-1:0]              ram_address,
  output logic [DW-1:0]              ram_data,
  output logic                       ram_wren,
  input  logic [DW-1:0]              ram_q
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][15:0]   stat_grants,
  output logic [15:0]                stat_conflicts
`endif
);

  logic    gnt_vld;
  req_id_t gnt_id;
  req_id_t rr_last_q;
  req_id_t rr_last_d;

  // Under contention the requester not served last wins; otherwise the lone one.
  always_comb begin
    gnt_vld   = |req_valid;
    gnt_id    = (&req_valid) ? ~rr_last_q : req_valid[1];
    req_ready = '0;
    if (gnt_vld) req_ready[gnt_id] = 1'b1;
    rr_last_d = gnt_vld ? gnt_id : rr_last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_last_q <= 1'b1;
    else     rr_last_q <= rr_last_d;
  end

  always_comb begin
    ram_address = '0;
    ram_data    = '0;
    ram_wren    = 1'b0;
    if (gnt_vld) begin
      ram_address = req_addr[gnt_id];
      ram_data    = req_wdata[gnt_id];
      ram_wren    = req_we[gnt_id];
    end
  end

  ram_rd_tag_pipe #(
    .RD_LAT (RD_LAT),
    .DW     (DW)
  ) u_tag_pipe (
    .clk         (clk),
    .rst         (rst),
    .rd_acc_i    (gnt_vld && !req_we[gnt_id]),
    .rd_id_i     (gnt_id),
    .ram_q_i     (ram_q),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata)
  );

`ifdef RAM_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [NUM_REQ-1:0][15:0] grants_q;
  logic [NUM_REQ-1:0][15:0] grants_d;
  logic [15:0]              confl_q;
  logic [15:0]              confl_d;

  always_comb begin
    grants_d = grants_q;
    confl_d  = confl_q;
    if (gnt_vld)    grants_d[gnt_id] = sat_inc(grants_q[gnt_id]);
    if (&req_valid) confl_d = sat_inc(confl_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grants_q <= '0;
      confl_q  <= '0;
    end else begin
      grants_q <= grants_d;
      confl_q  <= confl_d;
    end
  end

  assign stat_grants    = grants_q;
  assign stat_conflicts = confl_q;
`endif

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Round-robin arbiter that shares one single-port `ram_v1` instance (1024 × 32) between two requesters, typically the button/counter read path and a switch-driven write path on the board test environment. Each requester gets a valid/ready request channel and a read-response channel. The arbiter steers address, data and write-enable to the RAM. It tracks in-flight reads through a latency tag pipeline so that each read result is returned to the requester that issued it.

## Interface
Parameters:
- `AW`, default 10: RAM address width.
- `DW`, default 32: RAM data width.
- `RD_LAT`, default 1: cycles from RAM address sample to valid `q`. Legal range 1..4.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous, active-high reset.
- `req_valid`, in, [1:0]: request present, one bit per requester.
- `req_we`, in, [1:0]: 1 = write, 0 = read.
- `req_addr`, in, [1:0][AW-1:0]: request address.
- `req_wdata`, in, [1:0][DW-1:0]: write data.
- `req_ready`, out, [1:0]: request accepted this cycle.
- `rsp_valid`, out, [1:0]: read data valid, one-cycle pulse.
- `rsp_rdata`, out, [DW-1:0]: read data, shared by both requesters and qualified by `rsp_valid`.
- `ram_address`, out, AW: to RAM.
- `ram_data`, out, DW: to RAM.
- `ram_wren`, out, 1: to RAM.
- `ram_q`, in, DW: from RAM.

## Operation
Arbitration:
- Combinational, one grant per cycle.
- `req_ready[i] = grant[i]`. A transfer occurs when `req_valid[i] && req_ready[i]`.
- Register `rr_last` (1 bit) holds the last granted requester.
- Only one requester valid: it is granted.
- Both valid: grant `~rr_last`.
- On every transfer, `rr_last` takes the granted index. With no transfer, `rr_last` holds.
- Requesters must hold `req_*` stable while `req_valid` is high and `req_ready` is low.

RAM drive:
- No grant: `ram_address = 0`, `ram_data = 0`, `ram_wren = 0`.
- Grant: `ram_address`, `ram_data` and `ram_wren` are the granted requester's `req_addr`, `req_wdata` and `req_we`.
- These outputs are combinational from the grant.

Read tag pipeline:
- Shift register of depth `RD_LAT`. Each entry is {valid, id}.
- Stage 0 loads {1, granted index} on an accepted read, and {0, x} otherwise.
- At the last stage: if valid, `rsp_valid[id] = 1` and `rsp_rdata = ram_q`.
- Writes never produce a response.
- Back-to-back reads from either requester are fully pipelined, sustaining one response per cycle.

Read-during-write: two accesses cannot hit the RAM in the same cycle, so no conflict case exists. A read issued in the cycle after a write to the same address returns the new data.

Reset:
- `rr_last = 1`, so requester 0 wins the first conflict.
- All tag valid bits are cleared. `rsp_valid = 0`, `req_ready = 0` when no request is valid, and the RAM outputs are 0.
- A reset during an in-flight read drops that response. No `rsp_valid` pulse is emitted for reads accepted before reset.

## Timing
- Accept-to-response latency for a read is exactly `RD_LAT` cycles. For example, accepted at edge N gives `rsp_valid` high in cycle N+`RD_LAT`.
- Writes complete at the accepting edge.
- Worst-case wait for a valid requester is 1 cycle under continuous contention.
- No combinational path from `ram_q` to `req_ready`.

## Configuration
Macro `RAM_ARB_STATS_EN`:
- Defined:
  - Adds outputs `stat_grants`, [1:0][15:0], and `stat_conflicts`, 16-bit.
  - `stat_grants[i]` increments on each transfer by requester i.
  - `stat_conflicts` increments in each cycle where both `req_valid` bits are high.
  - All counters saturate at 16'hFFFF and clear on `rst`.
- Undefined: these ports and all counter logic are absent. Arbitration behaviour is identical either way.

## Structure
Package `ram_arb_pkg` holds:
- `AW_DEF`, `DW_DEF`, `NUM_REQ = 2`.
- typedef `req_id_t` (1 bit).
- typedef `rd_tag_t` as a struct {logic valid; req_id_t id;}.

Sub-module `ram_rd_tag_pipe`: parameterised depth `RD_LAT`. It contains the tag shift register and the response demux.

## Test plan
- **Reset:** Assert `rst` for 2 cycles with `req_valid = 2'b11`.
  - During reset: `rsp_valid = 0`.
  - After release: first grant goes to requester 0.
- **Single write then read:** Requester 1 writes 0xDEADBEEF to address 0x005, then reads address 0x005.
  - The read response arrives `RD_LAT` cycles after acceptance.
  - `rsp_valid = 2'b10`, `rsp_rdata = 0xDEADBEEF`.
- **Contention:** Both requesters read continuously, requester 0 from address 0x010 and requester 1 from 0x020, for 8 cycles.
  - Grants alternate 0,1,0,1,…
  - Each requester receives 4 responses with the correct data.
- **Back-to-back pipelining:** Run with `RD_LAT = 2`. Requester 0 reads addresses 0..3 on consecutive cycles.
  - `rsp_valid[0]` is high for 4 consecutive cycles.
  - Data arrives in address order.
- **Reset mid-flight:** Accept a read, then assert `rst` on the next edge.
  - No `rsp_valid` pulse occurs for that read.
- **Statistics (`RAM_ARB_STATS_EN` defined):** Run 10 conflict cycles.
  - `stat_conflicts = 10`.
  - `stat_grants = {5, 5}`.
